// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Fetch-stage bundle: hazard/branch control, instruction ROM
//               port and IF/ID pipeline register outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int IM_AW = 10
);
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [IM_AW-1:0]  im_addr;
    logic [31:0]       im_instr;
    logic [31:0]       pc;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc;
    logic              if_id_valid;
    logic              if_id_fault;

    // master: the fetch unit itself
    modport master (
        input  stall, redirect, redirect_pc, im_instr,
        output im_addr, pc, if_id_instr, if_id_pc, if_id_valid, if_id_fault
    );

    // slave: control logic, instruction ROM and decoder around the fetch unit
    modport slave (
        output stall, redirect, redirect_pc, im_instr,
        input  im_addr, pc, if_id_instr, if_id_pc, if_id_valid, if_id_fault
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : MIPS fetch stage - PC register, instruction ROM addressing,
//               IF/ID register with stall, redirect and illegal-fetch fault.
//               Optional macro DELAY_SLOT_EN: redirect keeps the delay slot.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_AW    = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_fetch_unit_if.master bus
);

    // One past the last legal byte; 33 bits so the window end cannot wrap.
    localparam logic [32:0] c_win_end = {1'b0, PC_RESET} + (33'd4 << IM_AW);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic        r_if_id_fault;

    logic [31:0] w_pc_next;
    logic [31:0] w_instr_next;
    logic [31:0] w_ipc_next;
    logic        w_valid_next;
    logic        w_fault_next;
    logic        w_illegal;
    logic [31:0] w_fetch_instr;

    // PC_RESET is word aligned, so the low two bits never borrow into the word index.
    assign bus.im_addr = r_pc[IM_AW+1:2] - PC_RESET[IM_AW+1:2];

    assign w_illegal = (r_pc[1:0] != 2'b00)
                     | (r_pc < PC_RESET)
                     | ({1'b0, r_pc} >= c_win_end);

    assign w_fetch_instr = w_illegal ? 32'h0000_0000 : bus.im_instr;

    always_comb begin
        w_pc_next    = r_pc;
        w_instr_next = r_if_id_instr;
        w_ipc_next   = r_if_id_pc;
        w_valid_next = r_if_id_valid;
        w_fault_next = r_if_id_fault;
        if (bus.stall) begin
            w_pc_next = r_pc;
        end else if (bus.redirect) begin
            w_pc_next = bus.redirect_pc;
`ifdef DELAY_SLOT_EN
            w_instr_next = w_fetch_instr;
            w_ipc_next   = r_pc;
            w_valid_next = 1'b1;
            w_fault_next = w_illegal;
`else
            w_instr_next = 32'h0000_0000;
            w_ipc_next   = 32'h0000_0000;
            w_valid_next = 1'b0;
            w_fault_next = 1'b0;
`endif
        end else begin
            w_pc_next    = r_pc + 32'd4;
            w_instr_next = w_fetch_instr;
            w_ipc_next   = r_pc;
            w_valid_next = 1'b1;
            w_fault_next = w_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= PC_RESET;
            r_if_id_instr <= 32'h0000_0000;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_valid <= 1'b0;
            r_if_id_fault <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_if_id_instr <= w_instr_next;
            r_if_id_pc    <= w_ipc_next;
            r_if_id_valid <= w_valid_next;
            r_if_id_fault <= w_fault_next;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.if_id_fault = r_if_id_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit (vector table plus
//               randomised stall/redirect scoreboard run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          c_im_aw = 10;
    localparam logic [31:0] c_base  = 32'h0000_3000;

    logic clk;
    logic reset;

    instr_fetch_unit_if #(.IM_AW(c_im_aw)) bus ();

    instr_fetch_unit #(.PC_RESET(c_base), .IM_AW(c_im_aw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word k holds 0x1000_0000 + k
    always_comb bus.im_instr = 32'h1000_0000 + {22'b0, bus.im_addr};

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic        fault;
    } entry_t;

    localparam int c_nvec = 24;
    vec_t   vecs [c_nvec];
    entry_t q [$];
    entry_t last;
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic vec_t v(logic r, logic s, logic d, logic [31:0] rpc,
                               logic [31:0] e_pc, logic [31:0] e_instr,
                               logic [31:0] e_ipc, logic ev, logic ef);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = d; x.rpc = rpc;
        x.e_pc = e_pc; x.e_instr = e_instr; x.e_ipc = e_ipc;
        x.e_valid = ev; x.e_fault = ef;
        return x;
    endfunction

    // Redirect cycle: delay-slot contents when enabled, otherwise a bubble.
    function automatic vec_t vr(logic [31:0] tgt, logic [31:0] ds_instr,
                                logic [31:0] ds_ipc, logic ds_fault);
`ifdef DELAY_SLOT_EN
        return v(1'b0, 1'b0, 1'b1, tgt, tgt, ds_instr, ds_ipc, 1'b1, ds_fault);
`else
        return v(1'b0, 1'b0, 1'b1, tgt, tgt, 32'h0, 32'h0, 1'b0, 1'b0);
`endif
    endfunction

    function automatic logic [31:0] rom_word(logic [31:0] a);
        return 32'h1000_0000 + (((a - c_base) >> 2) & 32'h3FF);
    endfunction

    function automatic logic is_legal(logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= c_base) && (a < c_base + 32'h1000);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d,
                         input logic [31:0] rpc);
        reset           = r;
        bus.stall       = s;
        bus.redirect    = d;
        bus.redirect_pc = rpc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] model_pc;
        logic [31:0] tgt;
        logic        s;
        logic        d;
        entry_t      fe;
        entry_t      bubble;

        vecs[0]  = v(1, 0, 0, 0,            32'h3000, 32'h0,         32'h0,    0, 0);
        vecs[1]  = v(0, 0, 0, 0,            32'h3004, 32'h1000_0000, 32'h3000, 1, 0);
        vecs[2]  = v(0, 0, 0, 0,            32'h3008, 32'h1000_0001, 32'h3004, 1, 0);
        vecs[3]  = v(0, 1, 0, 0,            32'h3008, 32'h1000_0001, 32'h3004, 1, 0);
        vecs[4]  = v(0, 1, 0, 0,            32'h3008, 32'h1000_0001, 32'h3004, 1, 0);
        vecs[5]  = v(0, 1, 0, 0,            32'h3008, 32'h1000_0001, 32'h3004, 1, 0);
        vecs[6]  = v(0, 0, 0, 0,            32'h300C, 32'h1000_0002, 32'h3008, 1, 0);
        vecs[7]  = vr(32'h3040, 32'h1000_0003, 32'h300C, 0);
        vecs[8]  = v(0, 0, 0, 0,            32'h3044, 32'h1000_0010, 32'h3040, 1, 0);
        vecs[9]  = v(0, 1, 1, 32'h3080,     32'h3044, 32'h1000_0010, 32'h3040, 1, 0);
        vecs[10] = vr(32'h3080, 32'h1000_0011, 32'h3044, 0);
        vecs[11] = v(0, 0, 0, 0,            32'h3084, 32'h1000_0020, 32'h3080, 1, 0);
        vecs[12] = vr(32'h3002, 32'h1000_0021, 32'h3084, 0);
        vecs[13] = v(0, 0, 0, 0,            32'h3006, 32'h0,         32'h3002, 1, 1);
        vecs[14] = vr(32'h2FFC, 32'h0,         32'h3006, 1);
        vecs[15] = v(0, 0, 0, 0,            32'h3000, 32'h0,         32'h2FFC, 1, 1);
        vecs[16] = vr(32'h4000, 32'h1000_0000, 32'h3000, 0);
        vecs[17] = v(0, 0, 0, 0,            32'h4004, 32'h0,         32'h4000, 1, 1);
        vecs[18] = v(0, 0, 0, 0,            32'h4008, 32'h0,         32'h4004, 1, 1);
        vecs[19] = v(1, 1, 0, 0,            32'h3000, 32'h0,         32'h0,    0, 0);
        vecs[20] = v(1, 0, 1, 32'h3080,     32'h3000, 32'h0,         32'h0,    0, 0);
        vecs[21] = v(0, 0, 0, 0,            32'h3004, 32'h1000_0000, 32'h3000, 1, 0);
        vecs[22] = vr(32'h3FFC, 32'h1000_0001, 32'h3004, 0);
        vecs[23] = v(0, 0, 0, 0,            32'h4000, 32'h1000_03FF, 32'h3FFC, 1, 0);

        for (int i = 0; i < c_nvec; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            @(posedge clk);
            #1;
            chk("pc",          i, bus.pc,          vecs[i].e_pc);
            chk("im_addr",     i, {22'b0, bus.im_addr},
                ((vecs[i].e_pc - c_base) >> 2) & 32'h3FF);
            chk("if_id_instr", i, bus.if_id_instr, vecs[i].e_instr);
            chk("if_id_pc",    i, bus.if_id_pc,    vecs[i].e_ipc);
            chk("if_id_valid", i, {31'b0, bus.if_id_valid}, {31'b0, vecs[i].e_valid});
            chk("if_id_fault", i, {31'b0, bus.if_id_fault}, {31'b0, vecs[i].e_fault});
        end

        // Randomised stall/redirect run against a scoreboard of IF/ID entries.
        drive(1, 0, 0, 0);
        @(posedge clk);
        #1;
        model_pc = c_base;
        bubble   = '{instr: 32'h0, ipc: 32'h0, valid: 1'b0, fault: 1'b0};
        last     = bubble;
        chk("sb_reset_pc", 0, bus.pc, model_pc);

        for (int c = 0; c < 80; c++) begin
            s   = ($urandom_range(0, 3) == 0);
            d   = ($urandom_range(0, 4) == 0);
            tgt = c_base + ($urandom_range(1000, 1023) << 2);
            drive(0, s, d, tgt);
            if (!s) begin
                fe.instr = is_legal(model_pc) ? rom_word(model_pc) : 32'h0;
                fe.ipc   = model_pc;
                fe.valid = 1'b1;
                fe.fault = !is_legal(model_pc);
                if (d) begin
`ifdef DELAY_SLOT_EN
                    q.push_back(fe);
`else
                    q.push_back(bubble);
`endif
                    model_pc = tgt;
                end else begin
                    q.push_back(fe);
                    model_pc = model_pc + 32'd4;
                end
            end
            @(posedge clk);
            #1;
            if (!s) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty[%0d]: got empty queue, expected entry", c);
                end else begin
                    last = q.pop_front();
                end
            end
            chk("sb_pc",    c, bus.pc,          model_pc);
            chk("sb_instr", c, bus.if_id_instr, last.instr);
            chk("sb_ipc",   c, bus.if_id_pc,    last.ipc);
            chk("sb_flags", c, {30'b0, bus.if_id_valid, bus.if_id_fault},
                {30'b0, last.valid, last.fault});
        end

        drive(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
